// File: rtl/rx_prbs_check.sv
// rx_prbs_check: PRBS-31 receive checker with SEARCH/VERIFY/LOCKED sync and saturating status.
// Build option: define RX_PRBS_SELF_SYNC_EN to seed the LFSR from received data in SEARCH;
// otherwise SEARCH matches a start-of-frame beat against the first word from the seed.

module rx_prbs_check #(
  parameter int unsigned C_DATA_WIDTH    = 32,
  parameter int unsigned C_CNT_WIDTH     = 32,
  parameter int unsigned C_LOCK_COUNT    = 4,
  parameter int unsigned C_UNLOCK_ERRORS = 4
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    i_enable,
  input  logic                    i_cnt_clear,
  input  logic                    i_prbs_reload,
  input  logic [30:0]             i_prbs_seed,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_sof,
  input  logic                    s_axis_eof,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  output logic [1:0]              o_state,
  output logic                    o_locked,
  output logic                    o_err_beat,
  output logic [C_CNT_WIDTH-1:0]  o_beat_cnt,
  output logic [C_CNT_WIDTH-1:0]  o_bit_err_cnt,
  output logic [C_CNT_WIDTH-1:0]  o_err_beat_cnt,
  output logic [C_CNT_WIDTH-1:0]  o_frame_cnt
);

  localparam int unsigned PopW = $clog2(C_DATA_WIDTH + 1);
  localparam int unsigned AddW = ((PopW > C_CNT_WIDTH) ? PopW : C_CNT_WIDTH) + 1;

  typedef enum logic [1:0] {StIdle = 2'd0, StSearch = 2'd1, StVerify = 2'd2, StLocked = 2'd3} state_e;

  state_e                  state_q, state_d;
  logic [30:0]             lfsr_q, lfsr_d;
  logic [30:0]             seed_fix, gen_start, gen_adv, gen_s;
  logic                    gen_fb;
  logic [C_DATA_WIDTH-1:0] expected, err_vec;
  logic [PopW-1:0]         err_bits;
  logic                    beat_err, accept, tready_q;
  logic [7:0]              good_q, good_d, bad_q, bad_d;
  logic [8:0]              good_inc, bad_inc;
  logic                    err_pulse_q, err_pulse_d;
  logic [C_CNT_WIDTH-1:0]  beat_q, beat_d, bit_q, bit_d, errb_q, errb_d, frame_q, frame_d;

  function automatic logic [C_CNT_WIDTH-1:0] sat_add(input logic [C_CNT_WIDTH-1:0] a,
                                                     input logic [PopW-1:0] b);
    logic [AddW-1:0] sum;
    sum = AddW'(a) + AddW'(b);
    if (sum > AddW'({C_CNT_WIDTH{1'b1}})) return '1;
    return sum[C_CNT_WIDTH-1:0];
  endfunction

  assign seed_fix = (i_prbs_seed == '0) ? 31'h1 : i_prbs_seed;
  assign accept   = tready_q && s_axis_tvalid;
  assign err_vec  = s_axis_tdata ^ expected;
  assign beat_err = |err_vec;

  // Unroll C_DATA_WIDTH LFSR steps; SEARCH always compares against the seed's first word.
  always_comb begin
    gen_start = (state_q == StSearch) ? seed_fix : lfsr_q;
    gen_s     = gen_start;
    gen_fb    = 1'b0;
    expected  = '0;
    for (int i = 0; i < int'(C_DATA_WIDTH); i++) begin
      gen_fb                       = gen_s[30] ^ gen_s[27];
      expected[C_DATA_WIDTH-1-i]   = gen_fb;
      gen_s                        = {gen_s[29:0], gen_fb};
    end
    gen_adv = gen_s;
  end

  // Population count of the error vector.
  always_comb begin
    err_bits = '0;
    for (int i = 0; i < int'(C_DATA_WIDTH); i++) begin
      err_bits = err_bits + PopW'(err_vec[i]);
    end
  end

  // Sync state machine and LFSR next state; reload beats everything, disable beats the rest.
  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    good_d   = good_q;
    bad_d    = bad_q;
    good_inc = {1'b0, good_q} + 9'd1;
    bad_inc  = {1'b0, bad_q} + 9'd1;
    case (state_q)
      StIdle: begin
        if (i_enable) state_d = StSearch;
      end
      StSearch: begin
        if (accept) begin
`ifdef RX_PRBS_SELF_SYNC_EN
          lfsr_d  = s_axis_tdata[30:0];
          good_d  = '0;
          state_d = StVerify;
`else
          if (s_axis_sof) begin
            if (!beat_err) begin
              lfsr_d  = gen_adv;
              good_d  = 8'd1;
              bad_d   = '0;
              state_d = (C_LOCK_COUNT <= 1) ? StLocked : StVerify;
            end else begin
              lfsr_d = seed_fix;
            end
          end
`endif
        end
      end
      StVerify: begin
        if (accept) begin
          lfsr_d = gen_adv;
          if (beat_err) begin
            good_d  = '0;
            state_d = StSearch;
          end else begin
            good_d = good_inc[7:0];
            if (good_inc >= 9'(C_LOCK_COUNT)) begin
              bad_d   = '0;
              state_d = StLocked;
            end
          end
        end
      end
      StLocked: begin
        if (accept) begin
          lfsr_d = gen_adv;
          if (beat_err) begin
            bad_d = bad_inc[7:0];
            if (bad_inc >= 9'(C_UNLOCK_ERRORS)) begin
              bad_d   = '0;
              state_d = StSearch;
            end
          end else begin
            bad_d = '0;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (!i_enable) state_d = StIdle;
    if (i_prbs_reload) begin
      lfsr_d  = seed_fix;
      good_d  = '0;
      bad_d   = '0;
      state_d = StSearch;
    end
  end

  // Status counters: LOCKED beats feed the error stats, eof counts in any active state.
  always_comb begin
    beat_d      = beat_q;
    bit_d       = bit_q;
    errb_d      = errb_q;
    frame_d     = frame_q;
    err_pulse_d = 1'b0;
    if (accept && state_q == StLocked) begin
      beat_d = sat_add(beat_q, PopW'(1));
      bit_d  = sat_add(bit_q, err_bits);
      if (beat_err) begin
        errb_d      = sat_add(errb_q, PopW'(1));
        err_pulse_d = 1'b1;
      end
    end
    if (accept && state_q != StIdle && s_axis_eof) frame_d = sat_add(frame_q, PopW'(1));
    if (i_cnt_clear) begin
      beat_d  = '0;
      bit_d   = '0;
      errb_d  = '0;
      frame_d = '0;
    end
  end

  // State, LFSR and status registers.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q     <= StIdle;
      lfsr_q      <= 31'h1;
      good_q      <= '0;
      bad_q       <= '0;
      tready_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      beat_q      <= '0;
      bit_q       <= '0;
      errb_q      <= '0;
      frame_q     <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      tready_q    <= i_enable;
      err_pulse_q <= err_pulse_d;
      beat_q      <= beat_d;
      bit_q       <= bit_d;
      errb_q      <= errb_d;
      frame_q     <= frame_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign o_state        = state_q;
  assign o_locked       = (state_q == StLocked);
  assign o_err_beat     = err_pulse_q;
  assign o_beat_cnt     = beat_q;
  assign o_bit_err_cnt  = bit_q;
  assign o_err_beat_cnt = errb_q;
  assign o_frame_cnt    = frame_q;

endmodule

// File: tb/tb_rx_prbs_check.sv
// tb_rx_prbs_check: randomized bench for rx_prbs_check (32-bit instance with a reference model,
// plus a 128-bit instance with 4-bit counters for the frame/saturation scenario).

module tb_rx_prbs_check;

  localparam int LockCount    = 4;
  localparam int UnlockErrors = 4;
  localparam longint MaxA     = 64'hFFFF_FFFF;

  logic        clk, rstn;
  // 32-bit instance
  logic        a_en, a_clr, a_reload, a_tready, a_valid, a_sof, a_eof, a_locked, a_errb;
  logic [30:0] a_seed;
  logic [31:0] a_data, a_beat_cnt, a_bit_cnt, a_errb_cnt, a_frame_cnt;
  logic [1:0]  a_state;
  // 128-bit instance
  logic         b_en, b_clr, b_reload, b_tready, b_valid, b_sof, b_eof, b_locked, b_errb;
  logic [30:0]  b_seed;
  logic [127:0] b_data;
  logic [3:0]   b_beat_cnt, b_bit_cnt, b_errb_cnt, b_frame_cnt;
  logic [1:0]   b_state;

  int n_checks, n_pass;
  bit arr [0:16383];
  int tx_pos;
  // reference model of the 32-bit instance
  int     m_state, m_good, m_bad, m_pos;
  logic   m_tready, m_errp;
  longint m_beat, m_bits, m_errb, m_frame;

  rx_prbs_check dut_a (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn), .i_enable(a_en), .i_cnt_clear(a_clr),
    .i_prbs_reload(a_reload), .i_prbs_seed(a_seed), .s_axis_tready(a_tready),
    .s_axis_tvalid(a_valid), .s_axis_sof(a_sof), .s_axis_eof(a_eof), .s_axis_tdata(a_data),
    .o_state(a_state), .o_locked(a_locked), .o_err_beat(a_errb), .o_beat_cnt(a_beat_cnt),
    .o_bit_err_cnt(a_bit_cnt), .o_err_beat_cnt(a_errb_cnt), .o_frame_cnt(a_frame_cnt)
  );

  rx_prbs_check #(.C_DATA_WIDTH(128), .C_CNT_WIDTH(4)) dut_b (
    .s_axi_aclk(clk), .s_axi_aresetn(rstn), .i_enable(b_en), .i_cnt_clear(b_clr),
    .i_prbs_reload(b_reload), .i_prbs_seed(b_seed), .s_axis_tready(b_tready),
    .s_axis_tvalid(b_valid), .s_axis_sof(b_sof), .s_axis_eof(b_eof), .s_axis_tdata(b_data),
    .o_state(b_state), .o_locked(b_locked), .o_err_beat(b_errb), .o_beat_cnt(b_beat_cnt),
    .o_bit_err_cnt(b_bit_cnt), .o_err_beat_cnt(b_errb_cnt), .o_frame_cnt(b_frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Word of w bits starting pos bits into the seed-1 sequence; earliest bit at the MSB.
  function automatic logic [127:0] word(input int pos, input int w);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = arr[31+pos+i];
    return r;
  endfunction

  function automatic longint sat(input longint x);
    return (x > MaxA) ? MaxA : x;
  endfunction

  task automatic model_step();
    int st, e;
    logic acc;
    logic [127:0] w;
    if (!rstn) begin
      m_state = 0; m_good = 0; m_bad = 0; m_pos = 0; m_tready = 0; m_errp = 0;
      m_beat = 0; m_bits = 0; m_errb = 0; m_frame = 0;
      return;
    end
    st = m_state;
    acc = m_tready && a_valid;
    m_errp = 0;
    if (acc && st != 0) begin
      if (a_eof) m_frame = sat(m_frame + 1);
      if (st == 1) begin
        w = word(0, 32);
        if (a_sof && a_data == w[31:0]) begin
          m_pos = 32; m_good = 1;
          m_state = (m_good >= LockCount) ? 3 : 2;
        end
      end else begin
        w = word(m_pos, 32);
        e = $countones(a_data ^ w[31:0]);
        m_pos += 32;
        if (st == 2) begin
          if (e != 0) begin m_state = 1; m_good = 0; end
          else begin
            m_good++;
            if (m_good >= LockCount) begin m_state = 3; m_bad = 0; end
          end
        end else begin
          m_beat = sat(m_beat + 1);
          m_bits = sat(m_bits + e);
          if (e != 0) begin
            m_errb = sat(m_errb + 1); m_errp = 1; m_bad++;
            if (m_bad >= UnlockErrors) begin m_state = 1; m_bad = 0; end
          end else m_bad = 0;
        end
      end
    end
    if (st == 0 && a_en) m_state = 1;
    if (!a_en) m_state = 0;
    if (a_reload) m_state = 1;
    if (a_clr) begin m_beat = 0; m_bits = 0; m_errb = 0; m_frame = 0; end
    m_tready = a_en;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Present one beat to the 32-bit instance after 0..2 idle cycles.
  task automatic drive_a(input logic [31:0] d, input logic sof, input logic eof);
    int gaps;
    gaps = $urandom_range(0, 2);
    for (int g = 0; g < gaps; g++) begin
      a_valid = 0; a_sof = 0; a_eof = 0; a_data = $urandom;
      tick();
    end
    a_valid = 1; a_sof = sof; a_eof = eof; a_data = d;
    tick();
    a_valid = 0; a_sof = 0; a_eof = 0;
  endtask

  task automatic relock_a();
    logic [127:0] w;
    tx_pos = 0;
    for (int i = 0; i < LockCount; i++) begin
      w = word(tx_pos, 32);
      drive_a(w[31:0], i == 0, 1'b0);
      tx_pos += 32;
    end
  endtask

  task automatic test_reset();
    rstn = 0;
    tick(); tick();
    n_checks++; if (a_tready !== 1'b0) $display("FAIL reset_tready got %b want 0", a_tready); else n_pass++;
    n_checks++; if (a_state !== 2'd0) $display("FAIL reset_state got %0d want 0", a_state); else n_pass++;
    n_checks++; if (a_locked !== 1'b0 || a_errb !== 1'b0)
      $display("FAIL reset_flags got locked=%b err=%b want 0 0", a_locked, a_errb); else n_pass++;
    n_checks++; if ((a_beat_cnt | a_bit_cnt | a_errb_cnt | a_frame_cnt) !== 32'd0)
      $display("FAIL reset_counters got %0d %0d %0d %0d want 0", a_beat_cnt, a_bit_cnt,
               a_errb_cnt, a_frame_cnt); else n_pass++;
    n_checks++; if (b_state !== 2'd0 || b_tready !== 1'b0)
      $display("FAIL reset_b got state=%0d tready=%b want 0 0", b_state, b_tready); else n_pass++;
    rstn = 1;
    tick();
    n_checks++; if (a_state !== 2'(m_state)) $display("FAIL idle_hold got %0d want %0d", a_state, m_state); else n_pass++;
  endtask

  task automatic test_lock();
    logic [127:0] w;
    a_en = 1;
    tick();
    n_checks++; if (a_state !== 2'(m_state) || a_tready !== m_tready)
      $display("FAIL enable_search got %0d/%b want %0d/%b", a_state, a_tready, m_state, m_tready); else n_pass++;
    tx_pos = 0;
    for (int i = 0; i < LockCount; i++) begin
      w = word(tx_pos, 32);
      drive_a(w[31:0], i == 0, 1'b0);
      tx_pos += 32;
      n_checks++; if (a_state !== 2'(m_state)) $display("FAIL lock_state beat %0d got %0d want %0d", i, a_state, m_state); else n_pass++;
    end
    n_checks++; if (a_locked !== 1'b1) $display("FAIL lock_after_n got %b want 1", a_locked); else n_pass++;
    for (int i = 0; i < 100; i++) begin
      w = word(tx_pos, 32);
      drive_a(w[31:0], 1'b0, $urandom_range(0, 3) == 0);
      tx_pos += 32;
      n_checks++; if (a_state !== 2'(m_state) || a_errb !== m_errp)
        $display("FAIL clean_beat %0d got %0d/%b want %0d/%b", i, a_state, a_errb, m_state, m_errp); else n_pass++;
    end
    n_checks++; if (a_beat_cnt !== 32'd100) $display("FAIL beat_cnt got %0d want 100", a_beat_cnt); else n_pass++;
    n_checks++; if (a_bit_cnt !== 32'd0) $display("FAIL bit_err_clean got %0d want 0", a_bit_cnt); else n_pass++;
    n_checks++; if (a_frame_cnt !== 32'(m_frame)) $display("FAIL frame_cnt got %0d want %0d", a_frame_cnt, m_frame); else n_pass++;
  endtask

  task automatic test_bit_errors();
    logic [127:0] w;
    logic [31:0] flips [2];
    int pulses;
    flips[0] = 32'h20; flips[1] = 32'h7; pulses = 0;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) begin
        w = word(tx_pos, 32); drive_a(w[31:0], 1'b0, 1'b0); tx_pos += 32;
        if (a_errb === 1'b1) pulses++;
      end
      w = word(tx_pos, 32); drive_a(w[31:0] ^ flips[k], 1'b0, 1'b0); tx_pos += 32;
      if (a_errb === 1'b1) pulses++;
      n_checks++; if (a_errb !== m_errp) $display("FAIL err_pulse %0d got %b want %b", k, a_errb, m_errp); else n_pass++;
    end
    w = word(tx_pos, 32); drive_a(w[31:0], 1'b0, 1'b0); tx_pos += 32;
    if (a_errb === 1'b1) pulses++;
    n_checks++; if (pulses != 2) $display("FAIL err_pulse_count got %0d want 2", pulses); else n_pass++;
    n_checks++; if (a_errb_cnt !== 32'd2) $display("FAIL err_beat_cnt got %0d want 2", a_errb_cnt); else n_pass++;
    n_checks++; if (a_bit_cnt !== 32'd4) $display("FAIL bit_err_cnt got %0d want 4", a_bit_cnt); else n_pass++;
    n_checks++; if (a_state !== 2'd3) $display("FAIL stay_locked got %0d want 3", a_state); else n_pass++;
  endtask

  task automatic test_cnt_clear();
    logic [127:0] w;
    w = word(tx_pos, 32);
    a_clr = 1; a_valid = 1; a_eof = 1; a_data = w[31:0] ^ 32'(1 << $urandom_range(0, 31));
    tick();
    a_clr = 0; a_valid = 0; a_eof = 0; tx_pos += 32;
    n_checks++; if ((a_beat_cnt | a_bit_cnt | a_errb_cnt | a_frame_cnt) !== 32'd0)
      $display("FAIL clear_wins got %0d %0d %0d %0d want 0", a_beat_cnt, a_bit_cnt, a_errb_cnt,
               a_frame_cnt); else n_pass++;
    n_checks++; if (a_errb !== m_errp) $display("FAIL clear_pulse got %b want %b", a_errb, m_errp); else n_pass++;
    w = word(tx_pos, 32); drive_a(w[31:0], 1'b0, 1'b0); tx_pos += 32;
    n_checks++; if (a_beat_cnt !== 32'(m_beat)) $display("FAIL post_clear_beat got %0d want %0d", a_beat_cnt, m_beat); else n_pass++;
  endtask

  task automatic test_unlock();
    for (int i = 0; i < UnlockErrors; i++) begin
      drive_a(32'd0, 1'b0, 1'b0);
      tx_pos += 32;
      n_checks++; if (a_state !== 2'(m_state)) $display("FAIL unlock_state beat %0d got %0d want %0d", i, a_state, m_state); else n_pass++;
    end
    n_checks++; if (a_state !== 2'd1) $display("FAIL unlock_search got %0d want 1", a_state); else n_pass++;
    n_checks++; if (a_errb_cnt !== 32'(m_errb) || a_bit_cnt !== 32'(m_bits))
      $display("FAIL unlock_counts got %0d/%0d want %0d/%0d", a_errb_cnt, a_bit_cnt, m_errb, m_bits); else n_pass++;
    drive_a($urandom, 1'b0, 1'b0);
    drive_a($urandom, 1'b1, 1'b0);
    n_checks++; if (a_state !== 2'(m_state)) $display("FAIL search_reject got %0d want %0d", a_state, m_state); else n_pass++;
    relock_a();
    n_checks++; if (a_state !== 2'd3) $display("FAIL relock got %0d want 3", a_state); else n_pass++;
  endtask

  task automatic test_reload();
    a_reload = 1;
    tick();
    a_reload = 0;
    n_checks++; if (a_state !== 2'd1) $display("FAIL reload_state got %0d want 1", a_state); else n_pass++;
    n_checks++; if (a_beat_cnt !== 32'(m_beat)) $display("FAIL reload_counters got %0d want %0d", a_beat_cnt, m_beat); else n_pass++;
    relock_a();
    n_checks++; if (a_state !== 2'd3) $display("FAIL reload_relock got %0d want 3", a_state); else n_pass++;
  endtask

  task automatic test_enable_drop();
    logic [127:0] w;
    w = word(tx_pos, 32);
    a_en = 0; a_valid = 1; a_eof = 0; a_data = w[31:0];
    tick();
    a_valid = 0; tx_pos += 32;
    n_checks++; if (a_state !== 2'd0 || a_tready !== 1'b0)
      $display("FAIL drop_idle got %0d/%b want 0/0", a_state, a_tready); else n_pass++;
    n_checks++; if (a_beat_cnt !== 32'(m_beat)) $display("FAIL drop_last_beat got %0d want %0d", a_beat_cnt, m_beat); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1; a_eof = 1; a_data = $urandom;
      tick();
    end
    a_valid = 0; a_eof = 0;
    n_checks++; if (a_beat_cnt !== 32'(m_beat) || a_frame_cnt !== 32'(m_frame))
      $display("FAIL drop_hold got %0d/%0d want %0d/%0d", a_beat_cnt, a_frame_cnt, m_beat, m_frame); else n_pass++;
    a_en = 1;
    tick();
    n_checks++; if (a_state !== 2'd1 || a_tready !== 1'b1)
      $display("FAIL reenable got %0d/%b want 1/1", a_state, a_tready); else n_pass++;
  endtask

  task automatic test_frames_128();
    int bpos, frames, gaps;
    b_en = 1;
    tick();
    n_checks++; if (b_state !== 2'd1) $display("FAIL b_search got %0d want 1", b_state); else n_pass++;
    bpos = 0; frames = 0;
    for (int i = 0; i < 80; i++) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        b_valid = 0; b_data = {4{$urandom}};
        tick();
      end
      b_data = word(bpos, 128); b_valid = 1; b_sof = (i % 8 == 0); b_eof = (i % 8 == 7);
      tick();
      b_valid = 0; b_sof = 0; b_eof = 0; bpos += 128;
      n_checks++; if (b_state !== ((i < LockCount - 1) ? 2'd2 : 2'd3))
        $display("FAIL b_state beat %0d got %0d want %0d", i, b_state, (i < LockCount - 1) ? 2 : 3); else n_pass++;
      if (i % 8 == 7) begin
        frames++;
        n_checks++; if (b_frame_cnt !== 4'(frames)) $display("FAIL b_frame got %0d want %0d", b_frame_cnt, frames); else n_pass++;
      end
    end
    n_checks++; if (b_frame_cnt !== 4'd10) $display("FAIL b_frames_total got %0d want 10", b_frame_cnt); else n_pass++;
    n_checks++; if (b_beat_cnt !== 4'hF) $display("FAIL b_beat_saturate got %0d want 15", b_beat_cnt); else n_pass++;
    n_checks++; if (b_bit_cnt !== 4'd0 || b_errb_cnt !== 4'd0)
      $display("FAIL b_errors got %0d/%0d want 0/0", b_bit_cnt, b_errb_cnt); else n_pass++;
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    for (int i = 0; i < 31; i++) arr[i] = (i == 30);
    for (int j = 31; j < 16384; j++) arr[j] = arr[j-31] ^ arr[j-28];
    a_en = 0; a_clr = 0; a_reload = 0; a_seed = 31'h1; a_valid = 0; a_sof = 0; a_eof = 0;
    a_data = '0;
    b_en = 0; b_clr = 0; b_reload = 0; b_seed = 31'h0; b_valid = 0; b_sof = 0; b_eof = 0;
    b_data = '0;
    rstn = 0;
    test_reset();
    test_lock();
    test_bit_errors();
    test_cnt_clear();
    test_unlock();
    test_reload();
    test_enable_drop();
    test_frames_128();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rx_prbs_check.md
# rx_prbs_check

Parametrised PRBS-31 receive checker for the receive data path. It accepts AXI-Stream beats from the link, generates the expected PRBS word for each beat, and runs a SEARCH/VERIFY/LOCKED synchronisation state machine. It keeps saturating beat, bit-error, errored-beat and frame counters that the control plane reads as status. It is the generalised successor to the fixed 32-bit receiver: data width is configurable, lock and unlock are automatic, and bit-error accounting is built in.

## Interface
- C_DATA_WIDTH, 32: beat width in bits. Must be 32..128 and a multiple of 8.
- C_CNT_WIDTH, 32: width of every status counter.
- C_LOCK_COUNT, 4: consecutive error-free beats in VERIFY needed to enter LOCKED (1..255).
- C_UNLOCK_ERRORS, 4: consecutive errored beats in LOCKED that force a return to SEARCH (1..255).

Ports:
- s_axi_aclk  in  1  sole clock.
- s_axi_aresetn  in  1  reset, synchronous, active-low.
- i_enable  in  1  checker enable (level).
- i_cnt_clear  in  1  one-cycle pulse; clears all counters.
- i_prbs_reload  in  1  one-cycle pulse; reloads the LFSR from i_prbs_seed and sets state to SEARCH.
- i_prbs_seed  in  31  LFSR seed. A seed of 0 is replaced by 31'h1.
- s_axis_tready  out  1  accept strobe to the upstream source.
- s_axis_tvalid  in  1  beat valid.
- s_axis_sof  in  1  start-of-frame flag, qualified by tvalid.
- s_axis_eof  in  1  end-of-frame flag, qualified by tvalid.
- s_axis_tdata  in  C_DATA_WIDTH  beat data. tdata[MSB] is the earliest bit in time.
- o_state  out  2  0=IDLE, 1=SEARCH, 2=VERIFY, 3=LOCKED.
- o_locked  out  1  high while state is LOCKED.
- o_err_beat  out  1  one-cycle pulse per errored beat checked in LOCKED.
- o_beat_cnt  out  C_CNT_WIDTH  beats checked in LOCKED.
- o_bit_err_cnt  out  C_CNT_WIDTH  total mismatched bits in LOCKED.
- o_err_beat_cnt  out  C_CNT_WIDTH  errored beats in LOCKED.
- o_frame_cnt  out  C_CNT_WIDTH  accepted beats with eof=1, counted in any non-IDLE state.

## Operation
- Accept condition: s_axis_tready && s_axis_tvalid.
- s_axis_tready is a register: it follows i_enable with a one-cycle delay.
- Sequence definition: b(k) = b(k-31) XOR b(k-28).
- LFSR register s holds the previous 31 bits, with s[0] the newest and s[30] the oldest. Each step emits s[30]^s[27] and shifts that bit into s[0].
- Expected word for a beat is the next C_DATA_WIDTH steps. The first step maps to tdata[MSB].
- In VERIFY and LOCKED, the LFSR advances C_DATA_WIDTH steps on every accepted beat, whether or not the beat matched.
- Error vector = tdata XOR expected. Bit errors for a beat = popcount of the error vector. A beat is errored if popcount is nonzero.
- State transitions:
  - IDLE: entered on reset or when i_enable=0. Leaves to SEARCH when i_enable=1.
  - SEARCH: seeding behaviour is set by the configuration macro (see Configuration).
  - VERIFY: an errored beat returns to SEARCH and clears the good-beat run. After C_LOCK_COUNT consecutive good beats, go to LOCKED.
  - LOCKED: count every accepted beat. C_UNLOCK_ERRORS consecutive errored beats return to SEARCH. A good beat resets the errored-beat run.
- Counters saturate at all-ones and hold while disabled.
- i_cnt_clear wins over a simultaneous increment; the counter reads 0 afterwards.
- i_prbs_reload wins over any simultaneous transition. Counters are not affected by reload.
- If i_enable drops mid-frame: state goes to IDLE on the next cycle and tready deasserts on the next cycle. Beats accepted in that same cycle are still checked.

## Timing
- For a beat accepted in cycle N, all of the following update in cycle N+1: o_state, o_locked, o_err_beat and every counter. The LFSR also advances in N+1.
- Reset values: s_axis_tready=0, o_state=0, o_locked=0, o_err_beat=0, all counters=0, LFSR=31'h1.
- Throughput is one beat per cycle, with no bubbles.

## Configuration
- RX_PRBS_SELF_SYNC_EN defined:
  - In SEARCH, any accepted beat is not compared.
  - The LFSR loads s[i] = tdata[i] for i=0..30, so the newest bit lands in s[0].
  - State then goes to VERIFY. This works for any sequence phase.
- RX_PRBS_SELF_SYNC_EN undefined:
  - SEARCH ignores beats with sof=0.
  - A beat with sof=1 is compared against the first word generated from i_prbs_seed.
  - On a match, state goes to VERIFY with a good-beat run of 1 and the LFSR left advanced. On a mismatch, state stays in SEARCH and the LFSR is reset to the seed.

## Test plan
- Enable, send a clean PRBS stream from seed 31'h1, C_DATA_WIDTH=32 -> LOCKED after C_LOCK_COUNT checked beats. 100 further beats give o_beat_cnt=100, o_bit_err_cnt=0.
- While LOCKED, flip tdata[5] on one beat, then tdata[0..2] on another -> o_err_beat pulses twice, o_err_beat_cnt=2, o_bit_err_cnt=4, state stays LOCKED.
- While LOCKED, send 4 consecutive all-zero beats -> state is SEARCH in the cycle after the 4th beat. Then send a clean stream -> relock.
- Assert i_cnt_clear in the same cycle as an errored beat -> all counters read 0 on the next cycle.
- Drop i_enable mid-frame -> tready=0 and o_state=0 one cycle later, counters hold. Re-enable -> SEARCH.
- C_DATA_WIDTH=128: send 10 frames of 8 beats each, with eof on each 8th beat -> o_frame_cnt=10, lock is held throughout.
